// File: rtl/grid_io_cfg_array.sv
// grid_io_cfg_array: perimeter I/O tile with NUM_SUBTILE pad subtiles.
// Config is shifted serially into a staging chain (ccff_head -> ccff_tail)
// and copied to the active config only on a commit that follows exactly
// TOTAL shifts. Pads always run from the active config and never see a
// partial load.
// Per-subtile field map: b0 oe, b1 in_reg, b2 out_reg, b3 in_inv, rest reserved.
module grid_io_cfg_array #(
    parameter int NUM_SUBTILE = 8,
    parameter int CFG_BITS    = 4,
    localparam int TOTAL      = NUM_SUBTILE * CFG_BITS,
    localparam int CNT_W      = $clog2(TOTAL + 2)
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   ccff_head,
    input  logic                   ccff_en,
    input  logic                   ccff_commit,
    output logic                   ccff_tail,
    input  logic [NUM_SUBTILE-1:0] io_outpad,
    output logic [NUM_SUBTILE-1:0] io_inpad,
    inout  wire  [NUM_SUBTILE-1:0] gfpga_pad_GPIO_PAD,
    output logic                   cfg_valid,
    output logic                   cfg_err,
    output logic [CNT_W-1:0]       cfg_count
);

    localparam int F_OE      = 0;
    localparam int F_IN_REG  = 1;
    localparam int F_OUT_REG = 2;
    localparam int F_IN_INV  = 3;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_FULL,
        S_OVER
    } state_t;

    state_t                 state_q, state_d;
    logic [TOTAL-1:0]       sr_q, sr_d;
    logic [TOTAL-1:0]       cfg_q, cfg_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_SUBTILE-1:0] oreg_q;
    logic [NUM_SUBTILE-1:0] ireg_q;
    logic [NUM_SUBTILE-1:0] oe_eff;
    logic [NUM_SUBTILE-1:0] dout;
    logic [NUM_SUBTILE-1:0] din;

    // Config state registers: staging chain, active config, status, FSM
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cfg_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cfg_q   <= cfg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: commit has priority over shift; a commit with ccff_en
    // high is always a bad commit and suppresses the shift.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cfg_d   = cfg_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (ccff_commit) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            if ((state_q == S_FULL) && !ccff_en) begin
                cfg_d   = sr_q;
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (ccff_en) begin
            sr_d = {sr_q[TOTAL-2:0], ccff_head};
            if (cnt_q != CNT_OVER) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CNT_FULL) begin
                state_d = S_FULL;
            end else if (cnt_d == CNT_OVER) begin
                state_d = S_OVER;
            end else begin
                state_d = S_LOADING;
            end
        end
    end

    // Pad data flops: free-running on every edge, cleared only by reset
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            oreg_q <= '0;
            ireg_q <= '0;
        end else begin
            oreg_q <= io_outpad;
            ireg_q <= din;
        end
    end

    // Per-subtile datapath from the active config
    always_comb begin
        oe_eff   = '0;
        dout     = '0;
        din      = '0;
        io_inpad = '0;
        for (int unsigned k = 0; k < NUM_SUBTILE; k++) begin
            oe_eff[k]   = cfg_q[k*CFG_BITS + F_OE] & valid_q;
            dout[k]     = cfg_q[k*CFG_BITS + F_OUT_REG] ? oreg_q[k] : io_outpad[k];
            din[k]      = gfpga_pad_GPIO_PAD[k] ^ cfg_q[k*CFG_BITS + F_IN_INV];
            io_inpad[k] = cfg_q[k*CFG_BITS + F_IN_REG] ? ireg_q[k] : din[k];
        end
    end

    for (genvar g = 0; g < NUM_SUBTILE; g++) begin : g_pad
        assign gfpga_pad_GPIO_PAD[g] = oe_eff[g] ? dout[g] : 1'bz;
    end

    assign ccff_tail = sr_q[TOTAL-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;
    assign cfg_count = cnt_q;

endmodule
